seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the seven-segment decode datapath.
- Holds NUM_DIGITS 4-bit values and feeds them one at a time to the single shared segment decoder.
- Drives one-hot digit enables and inserts a blanking gap between digits to prevent ghosting.
- Host writes land in a shadow bank, which is committed to the active bank only at frame boundaries, so frames never tear.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_slot_timer.sv | 36 +++
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan path.
// Imported by the scan controller and its slot timer.
package seg_pkg;

   localparam int NIBBLE_W = 4;
   localparam int IDX_W    = 3;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } seg_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot prescaler: counts REFRESH_DIV cycles per digit slot
// and flags the end of the blank gap and of the whole slot.
module seg_slot_timer
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic blank_done,
   output logic slot_done,
   output logic slot_near
);

   localparam int CNT_W = clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt;

   assign blank_done = (cnt == CNT_W'(BLANK_CYCLES - 1));
   assign slot_done  = (cnt == CNT_W'(REFRESH_DIV - 1));
   assign slot_near  = (cnt == CNT_W'(REFRESH_DIV - 2));

   // Slot counter: wraps at the end of each slot, held at 0 while cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || slot_done) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with shadow/active value banks;
// host writes are committed to the active bank only at frame ends.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [NIBBLE_W-1:0]   wr_nibble,
   output logic [NIBBLE_W-1:0]   dec_nibble,
   output logic                  dec_blank,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  frame_tick
);

   localparam int BANK_N = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

   seg_state_e st, st_nxt;
   logic [IDX_W-1:0] dig, dig_nxt;

   logic [BANK_N-1:0][NIBBLE_W-1:0] shadow, active, active_nxt;

   logic clear, blank_done, slot_done, slot_near;
   logic load, wr_fire, ft_nxt, blank_nxt;
   logic [NUM_DIGITS-1:0] en_nxt;

   assign clear   = (st == IDLE) || !ena;
   assign load    = (st == IDLE) || frame_tick;
   assign wr_fire = wr_valid && wr_ready &&
                    ({1'b0, wr_idx} < 4'(NUM_DIGITS));

   seg_slot_timer #(
      .REFRESH_DIV  (REFRESH_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .blank_done (blank_done),
      .slot_done  (slot_done),
      .slot_near  (slot_near)
   );

   // Next state, next digit and the values the output registers take.
   always_comb begin
      st_nxt     = st;
      dig_nxt    = dig;
      unique case (st)
         IDLE: begin
            if (ena) st_nxt = BLANK;
         end
         BLANK: begin
            if (blank_done) st_nxt = SHOW;
         end
         SHOW: begin
            if (slot_done) begin
               st_nxt  = BLANK;
               dig_nxt = (dig == LAST) ? '0 : dig + IDX_W'(1);
            end
         end
         default: st_nxt = IDLE;
      endcase
      if (!ena) begin
         st_nxt  = IDLE;
         dig_nxt = '0;
      end
      ft_nxt     = ena && (st != IDLE) && (dig == LAST) && slot_near;
      en_nxt     = (st_nxt == SHOW) ? NUM_DIGITS'(1) << dig_nxt : '0;
      blank_nxt  = (st_nxt != SHOW);
      active_nxt = load ? shadow : active;
   end

   // State and digit index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st  <= IDLE;
         dig <= '0;
      end else begin
         st  <= st_nxt;
         dig <= dig_nxt;
      end
   end

   // Registered outputs; wr_ready drops only during the commit cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_en   <= '0;
         dec_blank  <= 1'b1;
         dec_nibble <= '0;
         frame_tick <= 1'b0;
         wr_ready   <= 1'b0;
      end else begin
         digit_en   <= en_nxt;
         dec_blank  <= blank_nxt;
         dec_nibble <= active_nxt[dig_nxt];
         frame_tick <= ft_nxt;
         wr_ready   <= !ft_nxt;
      end
   end

   // Shadow takes host writes; active follows shadow on commit or idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
      end else begin
         if (wr_fire) shadow[wr_idx] <= wr_nibble;
         active <= active_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 8-cycle slots,
// 2 blank cycles): predicted slots queued, monitor pops on show.
module tb_seg_scan_ctrl;

   typedef struct {
      logic [3:0] en;
      logic [3:0] nib;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_idx;
   logic [3:0] wr_nibble;
   logic [3:0] dec_nibble;
   logic       dec_blank;
   logic [3:0] digit_en;
   logic       frame_tick;

   exp_t exp_q[$];
   int   total;
   int   bad;
   int   k;
   logic [3:0] prev_en;

   seg_scan_ctrl #(
      .NUM_DIGITS   (4),
      .REFRESH_DIV  (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_idx     (wr_idx),
      .wr_nibble  (wr_nibble),
      .dec_nibble (dec_nibble),
      .dec_blank  (dec_blank),
      .digit_en   (digit_en),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)",
                  name, act, want, $time);
      end
   endtask

   task automatic push(input logic [3:0] en, input logic [3:0] nib);
      exp_t e;
      e.en  = en;
      e.nib = nib;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input logic [3:0] n0, input logic [3:0] n1,
                             input logic [3:0] n2, input logic [3:0] n3);
      push(4'b0001, n0);
      push(4'b0010, n1);
      push(4'b0100, n2);
      push(4'b1000, n3);
   endtask

   // Advance to scan cycle tgt, checking tick and blank timing each cycle.
   task automatic run_to(input int tgt);
      while (k < tgt) begin
         @(negedge clk);
         k++;
         chk("frame_tick", frame_tick, (k % 32) == 31);
         chk("dec_blank", dec_blank, (k % 8) < 2);
      end
   endtask

   task automatic wr_idle(input logic [2:0] idx, input logic [3:0] val);
      wr_valid  = 1'b1;
      wr_idx    = idx;
      wr_nibble = val;
      chk("wr_ready_idle", wr_ready, 1'b1);
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   // Monitor: invariants every cycle, scoreboard pop at each show start.
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (!$onehot0(digit_en) || (dec_blank && digit_en != 4'b0)) begin
            bad++;
            $display("FAIL invariant: en=%b blank=%b", digit_en, dec_blank);
         end
         if (digit_en != 4'b0 && prev_en == 4'b0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL slot_unexpected: en=%b nib=%0h",
                        digit_en, dec_nibble);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (digit_en !== e.en || dec_nibble !== e.nib) begin
                  bad++;
                  $display("FAIL slot: got en=%b nib=%0h want en=%b nib=%0h",
                           digit_en, dec_nibble, e.en, e.nib);
               end
            end
         end
      end
      prev_en = digit_en;
   end

   initial begin
      total     = 0;
      bad       = 0;
      k         = 0;
      prev_en   = 4'b0;
      rst_n     = 1'b0;
      ena       = 1'b0;
      wr_valid  = 1'b0;
      wr_idx    = 3'd0;
      wr_nibble = 4'd0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_digit_en", digit_en, 4'b0);
      chk("rst_nibble", dec_nibble, 4'h0);
      chk("rst_blank", dec_blank, 1'b1);
      chk("rst_tick", frame_tick, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("wr_ready_after_rst", wr_ready, 1'b1);

      // 1: free-running scan of zeros, two frames
      push_frame(4'h0, 4'h0, 4'h0, 4'h0);
      push_frame(4'h0, 4'h0, 4'h0, 4'h0);
      ena = 1'b1;
      k = -1;
      run_to(63);
      ena = 1'b0;
      @(negedge clk);
      chk("s1_off_en", digit_en, 4'b0);
      chk("s1_off_blank", dec_blank, 1'b1);

      // 2: preload while idle, then scan
      wr_idle(3'd0, 4'h1);
      wr_idle(3'd1, 4'h2);
      wr_idle(3'd2, 4'h3);
      wr_idle(3'd3, 4'h4);
      wr_idle(3'd5, 4'hF);
      push_frame(4'h1, 4'h2, 4'h3, 4'h4);
      ena = 1'b1;
      k = -1;

      // 3: mid-frame write lands next frame
      run_to(10);
      chk("s3_digit1", digit_en, 4'b0010);
      wr_valid  = 1'b1;
      wr_idx    = 3'd3;
      wr_nibble = 4'h9;
      chk("s3_wr_ready", wr_ready, 1'b1);
      run_to(11);
      wr_valid = 1'b0;
      push_frame(4'h1, 4'h2, 4'h3, 4'h9);

      // 4: write held across the commit cycle
      run_to(63);
      chk("s4_tick", frame_tick, 1'b1);
      chk("s4_wr_ready_commit", wr_ready, 1'b0);
      wr_valid  = 1'b1;
      wr_idx    = 3'd0;
      wr_nibble = 4'h7;
      run_to(64);
      chk("s4_wr_ready_next", wr_ready, 1'b1);
      run_to(65);
      wr_valid = 1'b0;
      push_frame(4'h1, 4'h2, 4'h3, 4'h9);
      push(4'b0001, 4'h7);
      push(4'b0010, 4'h2);
      push(4'b0100, 4'h3);

      // 5: drop ena during digit 2 show, then restart
      run_to(115);
      chk("s5_show_d2", digit_en, 4'b0100);
      ena = 1'b0;
      @(negedge clk);
      chk("s5_off_en", digit_en, 4'b0);
      chk("s5_off_blank", dec_blank, 1'b1);
      chk("s5_off_tick", frame_tick, 1'b0);
      repeat (2) @(negedge clk);
      push(4'b0001, 4'h7);
      push(4'b0010, 4'h2);
      ena = 1'b1;
      k = -1;
      run_to(1);
      chk("s5_gap", digit_en, 4'b0);
      run_to(2);
      chk("s5_first_show", digit_en, 4'b0001);

      // 6: async reset mid-show
      run_to(12);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6_en", digit_en, 4'b0);
      chk("s6_nib", dec_nibble, 4'h0);
      chk("s6_blank", dec_blank, 1'b1);
      chk("s6_tick", frame_tick, 1'b0);
      chk("s6_wr_ready", wr_ready, 1'b0);
      ena = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s6_wr_ready_rel", wr_ready, 1'b1);
      push_frame(4'h0, 4'h0, 4'h0, 4'h0);
      ena = 1'b1;
      k = -1;
      run_to(31);
      ena = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
